dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the debug/preload port that the bench uses to seed and inspect memory.
- Arbitrates round-robin and sequences each access as issue, fixed-latency wait, then response.
- Sits between the core/debug side and the dmem instance, inside core_top.

Parameters:
- DWIDTH, 32: data word width.
- AWIDTH, 4: word-address width (16-word dmem).
- MEM_LAT, 1: cycles from the mem_en cycle until mem_rdata is valid. Legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- req0_valid  in  1  core request valid.
- req0_we  in  1  core write enable.
- req0_addr  in  AWIDTH  core word address.
- req0_wdata  in  DWIDTH  core write data.
- req0_ready  out  1  core request accepted this cycle.
- rsp0_valid  out  1  core response pulse.
- rsp0_rdata  out  DWIDTH  core read data.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as the req0/rsp0 ports, for the debug port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All outputs 0; latched request and rdata registers cleared.
  - Any in-flight transaction is dropped; no response is ever issued for it.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: (state==IDLE) && grant==N.
  - Handshake completes when valid && ready; addr, we and wdata are latched; last_grant<=N; go to ACCESS.
  - No valid input: stay in IDLE.
- Grant rules:
  - Only one valid: grant it.
  - Both valid: grant the port that is not last_grant.
  - At most one ready is high in any cycle.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr, mem_wdata driven from the latch.
  - Latency counter loaded with MEM_LAT; go to WAIT.
- WAIT (MEM_LAT cycles):
  - mem_en=0; counter decrements each cycle.
  - On the last WAIT cycle, mem_rdata is captured (reads only; writes capture 0); go to RESP.
- RESP (1 cycle):
  - rspN_valid=1 for the granted port only, with rspN_rdata = captured value; go to IDLE.
  - rspN_rdata returns to 0 when rspN_valid=0.
- Timing relative to acceptance cycle 0:
  - mem_en high in cycle 1.
  - rsp_valid high in cycle MEM_LAT+2.
  - Next acceptance possible in cycle MEM_LAT+3.
- mem_* outputs are all 0 outside ACCESS.
- Requester rules: a requester may drop valid before ready with no side effect. After acceptance, the latch is used, so inputs may change freely.
- Writes also produce a response pulse; rdata=0 for writes.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 16 bits.
  - Each counter increments on its port's acceptance and saturates at 0xFFFF.
  - Both counters clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE/ACCESS/WAIT/RESP);
  - constants REQ_CORE=0 and REQ_DBG=1;
  - default DWIDTH/AWIDTH;
  - STAT_W=16.
- One sub-module, rr_arbiter2:
  - combinational two-way grant;
  - last_grant register updated on acceptance.
- FSM, latency counter and latches stay in dmem_arbiter.

Test Plan:
- Reset: assert rst=0 mid-WAIT, release -> all outputs 0, busy=0, no rsp pulse; the next port-0 read is serviced normally with rsp at cycle 3.
- Port-1 write, MEM_LAT=1, addr 0, wdata 1 -> req1_ready in cycle 0; cycle 1 mem_en=1, mem_we=1, mem_addr=0, mem_wdata=1; rsp1_valid in cycle 3 with rdata 0.
- Port-0 read of addr 0 after the previous write -> rsp0_valid in cycle 3 with rsp0_rdata=1; rsp1_valid stays 0.
- Both ports held valid for 4 transactions -> acceptance order 0,1,0,1; never two readys in one cycle; grant_cnt0=grant_cnt1=2 when DMEM_ARB_STATS_EN is defined.
- MEM_LAT=3, port-0 read of addr 5 preloaded with 273 -> mem_en in cycle 1, rsp0_valid in cycle 5 with rdata 273, busy high for cycles 1-5.
- Port-0 valid dropped before a grant while port 1 holds the arbiter -> no port-0 transaction issued and no rsp0 pulse.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Also used by dmem_arbiter when built with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned REQ_CORE   = 0;
  localparam int unsigned REQ_DBG    = 1;
  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned AWIDTH_DEF = 4;
  localparam int unsigned STAT_W     = 16;
  localparam int unsigned LAT_W      = 3;

  // Saturating increment for the grant statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of dmem_arbiter.
// The slave modport is the arbiter; the master modport is the core/debug/dmem side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
);

  logic              req0_valid;
  logic              req0_we;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DWIDTH-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DWIDTH-1:0] rsp1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; last_grant resets to the debug port so the core wins the first tie.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant_c
);

  logic last_q;

  // One-hot grant, only while enabled; a tie goes to the port not granted last.
  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant_c = last_q ? 2'b01 : 2'b10;
      end else begin
        grant_c = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant_c[REQ_DBG];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port dmem: issue, fixed-latency wait, respond.
// Optional grant statistics outputs are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DWIDTH  = DWIDTH_DEF,
  parameter int unsigned AWIDTH  = AWIDTH_DEF,
  parameter int unsigned MEM_LAT = 1
)(
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]    grant_cnt0,
  output logic [STAT_W-1:0]    grant_cnt1
`endif
);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q;
  logic              port_q;
  logic              we_q;
  logic [1:0]        grant_c;
  logic              accept_c;
  logic              last_wait_c;
  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DWIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;
  logic              busy_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == IDLE),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .accept  (accept_c),
    .grant_c (grant_c)
  );

  assign bus.req0_ready = grant_c[REQ_CORE];
  assign bus.req1_ready = grant_c[REQ_DBG];

  // Request fields of whichever port is granted this cycle.
  always_comb begin
    sel_we    = bus.req0_we;
    sel_addr  = bus.req0_addr;
    sel_wdata = bus.req0_wdata;
    if (grant_c[REQ_DBG]) begin
      sel_we    = bus.req1_we;
      sel_addr  = bus.req1_addr;
      sel_wdata = bus.req1_wdata;
    end
  end

  assign last_wait_c = (state_q == WAIT) && (cnt_q == LAT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          accept_c = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS:  state_d = WAIT;
      WAIT:    if (last_wait_c) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner/direction latch and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q <= 1'b0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept_c) begin
        port_q <= grant_c[REQ_DBG];
        we_q   <= sel_we;
      end
      if (state_q == ACCESS) begin
        cnt_q <= LAT_W'(MEM_LAT);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - LAT_W'(1);
      end
    end
  end

  // Registered outputs; the mem_* registers hold the accepted request for the ACCESS cycle only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      mem_en_q     <= accept_c;
      mem_we_q     <= accept_c & sel_we;
      mem_addr_q   <= accept_c ? sel_addr  : '0;
      mem_wdata_q  <= accept_c ? sel_wdata : '0;
      rsp0_valid_q <= last_wait_c & ~port_q;
      rsp1_valid_q <= last_wait_c &  port_q;
      rsp0_rdata_q <= (last_wait_c && !port_q && !we_q) ? bus.mem_rdata : '0;
      rsp1_rdata_q <= (last_wait_c &&  port_q && !we_q) ? bus.mem_rdata : '0;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;
  assign bus.busy       = busy_q;

`ifdef DMEM_ARB_STATS_EN
  // Per-port acceptance counters, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (accept_c && grant_c[REQ_CORE]) grant_cnt0 <= sat_inc(grant_cnt0);
      if (accept_c && grant_c[REQ_DBG])  grant_cnt1 <= sat_inc(grant_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance A uses MEM_LAT=1, instance B uses MEM_LAT=3.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_a ();
  dmem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_b ();

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] gc0_a, gc1_a, gc0_b, gc1_b;
`endif

  dmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(gc0_a), .grant_cnt1(gc1_a)
`endif
  );

  dmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(gc0_b), .grant_cnt1(gc1_b)
`endif
  );

  // Memory models: read data is valid exactly MEM_LAT cycles after the mem_en cycle.
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];
  logic [DW-1:0] pipe_a [1];
  logic [DW-1:0] pipe_b [3];

  always @(posedge clk) begin
    pipe_a[0] <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr] : 32'hDEAD_BEEF;
    if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
  end
  assign bus_a.mem_rdata = pipe_a[0];
  assign bus_b.mem_rdata = pipe_b[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   men_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  function automatic void mon(int inst, logic v0, logic v1, logic [31:0] d0, logic [31:0] d1,
                              logic rd0, logic rd1, logic vl0, logic vl1,
                              logic men, logic mwe, logic [3:0] maddr, logic [31:0] mwd);
    exp_t e;
    check($sformatf("one_ready[%0d]", inst), 32'(rd0 & rd1), 32'd0);
    if (rd0 && vl0) acc_log.push_back(inst * 2);
    if (rd1 && vl1) acc_log.push_back(inst * 2 + 1);
    if (men) men_cnt++;
    else check($sformatf("mem_idle[%0d]", inst), mwd | 32'(maddr) | 32'(mwe), 32'd0);
    if (!v0) check($sformatf("rsp0_rdata_idle[%0d]", inst), d0, 32'd0);
    if (!v1) check($sformatf("rsp1_rdata_idle[%0d]", inst), d1, 32'd0);
    if (v0 || v1) begin
      check($sformatf("one_rsp[%0d]", inst), 32'(v0 & v1), 32'd0);
      check($sformatf("rsp_expected[%0d]", inst), 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("rsp_inst[%0d]", inst), 32'(inst), 32'(e.inst));
        check($sformatf("rsp_port[%0d]", inst), 32'(v1), 32'(e.port));
        check($sformatf("rsp_rdata[%0d]", inst), v1 ? d1 : d0, e.rdata);
        check($sformatf("rsp_cycle[%0d]", inst), 32'(cyc), 32'(e.due));
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mon(0, bus_a.rsp0_valid, bus_a.rsp1_valid, bus_a.rsp0_rdata, bus_a.rsp1_rdata,
          bus_a.req0_ready, bus_a.req1_ready, bus_a.req0_valid, bus_a.req1_valid,
          bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
      mon(1, bus_b.rsp0_valid, bus_b.rsp1_valid, bus_b.rsp0_rdata, bus_b.rsp1_rdata,
          bus_b.req0_ready, bus_b.req1_ready, bus_b.req0_valid, bus_b.req1_valid,
          bus_b.mem_en, bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata);
    end
  end

  task automatic drive(int inst, int port, logic v, logic we, logic [3:0] addr, logic [31:0] wd);
    if (inst == 0 && port == 0) begin
      bus_a.req0_valid = v; bus_a.req0_we = we; bus_a.req0_addr = addr; bus_a.req0_wdata = wd;
    end else if (inst == 0) begin
      bus_a.req1_valid = v; bus_a.req1_we = we; bus_a.req1_addr = addr; bus_a.req1_wdata = wd;
    end else if (port == 0) begin
      bus_b.req0_valid = v; bus_b.req0_we = we; bus_b.req0_addr = addr; bus_b.req0_wdata = wd;
    end else begin
      bus_b.req1_valid = v; bus_b.req1_we = we; bus_b.req1_addr = addr; bus_b.req1_wdata = wd;
    end
  endtask

  function automatic logic get_ready(int inst, int port);
    if (inst == 0) return (port == 0) ? bus_a.req0_ready : bus_a.req1_ready;
    return (port == 0) ? bus_b.req0_ready : bus_b.req1_ready;
  endfunction

  function automatic logic get_busy(int inst);
    return (inst == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  // Holds valid until accepted, then queues the expected response; returns at posedge+1 after acceptance.
  task automatic do_req(int inst, int port, logic we, logic [3:0] addr, logic [31:0] wd,
                        logic [31:0] exp_rd, output int acc);
    int  lat;
    bit  done;
    exp_t e;
    lat  = (inst == 0) ? 1 : 3;
    done = 1'b0;
    acc  = -1;
    drive(inst, port, 1'b1, we, addr, wd);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (get_ready(inst, port)) begin
        done = 1'b1;
        acc  = cyc;
        e.inst = inst; e.port = port; e.rdata = we ? 32'd0 : exp_rd; e.due = cyc + lat + 2;
        sb.push_back(e);
      end
    end
    check($sformatf("accepted[%0d.%0d]", inst, port), 32'(done), 32'd1);
    @(posedge clk); #1;
    drive(inst, port, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic drain(int inst);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !get_busy(inst)) ok = 1'b1;
    end
    check($sformatf("drain[%0d]", inst), 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(string tag);
    check({tag, "_busy_a"},  32'(bus_a.busy), 32'd0);
    check({tag, "_men_a"},   32'(bus_a.mem_en), 32'd0);
    check({tag, "_rsp_a"},   32'({bus_a.rsp0_valid, bus_a.rsp1_valid}), 32'd0);
    check({tag, "_rdat_a"},  bus_a.rsp0_rdata | bus_a.rsp1_rdata, 32'd0);
    check({tag, "_mem_a"},   bus_a.mem_wdata | 32'(bus_a.mem_addr) | 32'(bus_a.mem_we), 32'd0);
    check({tag, "_busy_b"},  32'(bus_b.busy), 32'd0);
    check({tag, "_rsp_b"},   32'({bus_b.rsp0_valid, bus_b.rsp1_valid}), 32'd0);
`ifdef DMEM_ARB_STATS_EN
    check({tag, "_gc_a"},    32'({gc0_a, gc1_a}), 32'd0);
`endif
  endtask

  int a0, a1, b0, b1, n0, m0;
  int rr_exp[4] = '{0, 1, 0, 1};
`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] s0, s1;
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    pipe_a[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) pipe_b[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin drive(0, i, 0, 0, 0, 0); drive(1, i, 0, 0, 0, 0); end

    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    // Port-1 write addr 0 <- 1: accepted cycle 0, ACCESS in cycle 1.
    do_req(0, 1, 1'b1, 4'd0, 32'd1, 32'd0, a0);
    @(negedge clk);
    check("wr_men",   32'(bus_a.mem_en), 32'd1);
    check("wr_mwe",   32'(bus_a.mem_we), 32'd1);
    check("wr_maddr", 32'(bus_a.mem_addr), 32'd0);
    check("wr_mwd",   bus_a.mem_wdata, 32'd1);
    check("wr_busy",  32'(bus_a.busy), 32'd1);
    @(negedge clk);
    check("wr_men_c2", 32'(bus_a.mem_en), 32'd0);
    @(posedge clk); #1;
    drain(0);

    // Port-0 read of the value just written.
    do_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd1, a0);
    drain(0);
    do_req(0, 1, 1'b1, 4'd3, 32'hA5, 32'd0, a0);
    drain(0);

    // Both ports held valid: alternating grants.
    n0 = acc_log.size();
`ifdef DMEM_ARB_STATS_EN
    s0 = gc0_a; s1 = gc1_a;
`endif
    fork
      begin
        do_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd1, a0);
        do_req(0, 0, 1'b0, 4'd3, 32'd0, 32'hA5, a1);
      end
      begin
        do_req(0, 1, 1'b1, 4'd7, 32'h77, 32'd0, b0);
        do_req(0, 1, 1'b0, 4'd7, 32'd0, 32'h77, b1);
      end
    join
    drain(0);
    check("rr_count", 32'(acc_log.size() - n0), 32'd4);
    if (acc_log.size() - n0 >= 4)
      for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 32'(acc_log[n0 + i]), 32'(rr_exp[i]));
    check("rr_spacing", 32'(b0 - a0), 32'd4);
    check("rr_last", 32'(b1 - a1), 32'd4);
`ifdef DMEM_ARB_STATS_EN
    check("gc0_delta", 32'(STAT_W'(gc0_a - s0)), 32'd2);
    check("gc1_delta", 32'(STAT_W'(gc1_a - s1)), 32'd2);
`endif

    // Port 0 drops valid while port 1 holds the arbiter.
    n0 = acc_log.size();
    m0 = men_cnt;
    do_req(0, 1, 1'b1, 4'd9, 32'h99, 32'd0, b0);
    drive(0, 0, 1'b1, 1'b0, 4'd2, 32'd0);
    @(negedge clk);
    check("drop_rdy_c1", 32'(bus_a.req0_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_rdy_c2", 32'(bus_a.req0_ready), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 1'b0, 4'd0, 32'd0);
    drain(0);
    check("drop_acc_cnt", 32'(acc_log.size() - n0), 32'd1);
    if (acc_log.size() > n0) check("drop_acc_port", 32'(acc_log[n0]), 32'd1);
    check("drop_men_cnt", 32'(men_cnt - m0), 32'd1);

    // Reset in the WAIT cycle of a read: the response is dropped.
    do_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd1, a0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk_quiet("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("postrst");
    @(posedge clk); #1;
    do_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd1, a0);
    drain(0);

    // MEM_LAT=3 instance: preload addr 5 via debug port, then a timed core read.
    do_req(1, 1, 1'b1, 4'd5, 32'd273, 32'd0, b0);
    drain(1);
    do_req(1, 0, 1'b0, 4'd5, 32'd0, 32'd273, a0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("lat3_busy_c%0d", k), 32'(bus_b.busy), 32'(k <= 5));
      check($sformatf("lat3_men_c%0d", k), 32'(bus_b.mem_en), 32'(k == 1));
    end
    @(posedge clk); #1;
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
